// File: rtl/ahb_copy_master_if.sv
// AHB-Lite bus bundle between the copy master and the system bus.
interface ahb_copy_master_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output haddr, htrans, hwrite, hsize,
    output hburst, hprot, hmastlock, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize,
    input  hburst, hprot, hmastlock, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_copy_master.sv
// AHB-Lite block copy master: single read/write pairs, DONE/ERR status.
// Define AHB_COPY_CHECKSUM_EN to add the additive read-data checksum port.
module ahb_copy_master #(
  parameter int CNT_W = 16
) (
  input  logic             hclk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] count,
`ifdef AHB_COPY_CHECKSUM_EN
  output logic [31:0]      checksum,
`endif
  ahb_copy_master_if.master bus
);

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_NSEQ = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_D, WR_A, WR_D, FIN
  } state_t;

  state_t state, state_nx;

  logic [31:0]      src_ptr, dst_ptr, data_q;
  logic [CNT_W-1:0] len_q, count_q, count_inc;
  logic             err_q;
  logic             accept, rd_done, wr_done, bus_err;

  assign accept    = (state == IDLE) && start;
  assign rd_done   = (state == RD_D) && bus.hready && !bus.hresp;
  assign wr_done   = (state == WR_D) && bus.hready && !bus.hresp;
  assign bus_err   = ((state == RD_D) || (state == WR_D))
                     && bus.hready && bus.hresp;
  assign count_inc = count_q + CNT_W'(1);

  always_ff @(posedge hclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (len == '0) ? FIN : RD_A;
      RD_A: if (bus.hready) state_nx = RD_D;
      RD_D: begin
        if (bus_err)      state_nx = FIN;
        else if (rd_done) state_nx = WR_A;
      end
      WR_A: if (bus.hready) state_nx = WR_D;
      WR_D: begin
        if (bus_err)      state_nx = FIN;
        else if (wr_done) state_nx = (count_inc == len_q) ? FIN : RD_A;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address/control decode straight from state, so it cannot move mid-wait.
  always_comb begin
    bus.htrans = TR_IDLE;
    bus.hwrite = 1'b0;
    bus.haddr  = src_ptr;
    unique case (state)
      RD_A: bus.htrans = TR_NSEQ;
      WR_A: begin
        bus.htrans = TR_NSEQ;
        bus.hwrite = 1'b1;
        bus.haddr  = dst_ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      data_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        count_q <= '0;
        err_q   <= 1'b0;
        if (len != '0) begin
          src_ptr <= {src[31:2], 2'b00};
          dst_ptr <= {dst[31:2], 2'b00};
          len_q   <= len;
        end
      end
      if (rd_done) data_q <= bus.hrdata;
      if (wr_done) begin
        count_q <= count_inc;
        src_ptr <= src_ptr + 32'd4;
        dst_ptr <= dst_ptr + 32'd4;
      end
      if (bus_err) err_q <= 1'b1;
    end
  end

`ifdef AHB_COPY_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge hclk) begin
    if (reset)        sum_q <= '0;
    else if (accept)  sum_q <= '0;
    else if (rd_done) sum_q <= sum_q + bus.hrdata;
  end

  assign checksum = sum_q;
`endif

  assign busy  = (state == RD_A) || (state == RD_D)
              || (state == WR_A) || (state == WR_D);
  assign done  = (state == FIN);
  assign err   = err_q;
  assign count = count_q;

  assign bus.hwdata    = data_q;
  assign bus.hsize     = 3'b010;
  assign bus.hburst    = 3'b000;
  assign bus.hprot     = 4'b0011;
  assign bus.hmastlock = 1'b0;

endmodule

// File: tb/tb_ahb_copy_master.sv
// Bench for ahb_copy_master: RAM slave with wait/error injection,
// job table plus reset-mid-job sequence, write scoreboard.
module tb_ahb_copy_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] len = '0;
  logic        busy, done, err;
  logic [15:0] count;
`ifdef AHB_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int errors = 0;
  int checks = 0;

  ahb_copy_master_if bus ();

  ahb_copy_master #(.CNT_W(16)) dut (
    .hclk  (clk),
    .reset (reset),
    .start (start),
    .src   (src),
    .dst   (dst),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .count (count),
`ifdef AHB_COPY_CHECKSUM_EN
    .checksum (checksum),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] mem [0:1023];
  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic [31:0] dp_addr = '0;
  int          wcnt = 0;
  int          waits = 0;
  int          wr_total = 0;
  int          err_target = 0;
  wr_t         exp_q[$];
  wr_t         e;

  assign bus.hready = !dp_valid || (wcnt >= waits);
  assign bus.hresp  = dp_valid && dp_write && bus.hready
                      && (err_target != 0) && (wr_total + 1 == err_target);
  assign bus.hrdata = (dp_valid && !dp_write) ? mem[dp_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (reset) begin
      dp_valid <= 1'b0;
      wcnt     <= 0;
    end else if (bus.hready) begin
      if (dp_valid && dp_write && !bus.hresp) begin
        mem[dp_addr[11:2]] = bus.hwdata;
        wr_total <= wr_total + 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected none",
                   dp_addr, bus.hwdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", dp_addr, e.addr);
          check("wr_data", bus.hwdata, e.data);
        end
      end
      dp_valid <= (bus.htrans == 2'b10);
      dp_addr  <= bus.haddr;
      dp_write <= bus.hwrite;
      wcnt     <= 0;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  // Address/control must not move across a wait edge
  logic [31:0] p_haddr = '0;
  logic [1:0]  p_htrans = '0;
  logic        p_hready = 1'b1;
  logic        p_valid = 1'b0;

  always @(negedge clk) begin
    if (!reset && p_valid && !p_hready) begin
      check("wait_htrans", 32'(bus.htrans), 32'(p_htrans));
      check("wait_haddr", bus.haddr, p_haddr);
    end
    p_haddr  <= bus.haddr;
    p_htrans <= bus.htrans;
    p_hready <= bus.hready;
    p_valid  <= !reset;
  end

  // ---------------- job table ----------------
  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          waits;
    int          err_wr;
    int          base;
    int          cycles;
    int          cnt;
    logic        e;
  } job_t;

  job_t jobs [8];

  task automatic run_job(input job_t j);
    logic [31:0] sa, da, a, w, sum;
    int nrd, nwr, n;
    logic bs;
    sa  = {j.src[31:2], 2'b00};
    da  = {j.dst[31:2], 2'b00};
    nrd = (j.err_wr != 0) ? j.err_wr : j.len;
    nwr = (j.err_wr != 0) ? j.err_wr - 1 : j.len;
    sum = '0;
    for (int i = 0; i < j.len; i++) begin
      a = sa + 32'(4 * i);
      w = (j.base != 0) ? 32'(j.base + i) : $urandom;
      mem[a[11:2]] = w;
      if (i < nrd) sum = sum + w;
      if (i < nwr) exp_q.push_back('{da + 32'(4 * i), w});
    end
    waits      = j.waits;
    err_target = (j.err_wr != 0) ? wr_total + j.err_wr : 0;
    @(negedge clk);
    start = 1'b1;
    src   = j.src;
    dst   = j.dst;
    len   = 16'(j.len);
    @(posedge clk);
    #1 start = 1'b0;
    n  = 1;
    bs = 1'b0;
    @(negedge clk);
    check("busy_c1", 32'(busy), 32'(j.len != 0));
    while (!done && n < 2000) begin
      if (busy) bs = 1'b1;
      @(negedge clk);
      n++;
    end
    check("done_cycle", n, j.cycles);
    check("count", 32'(count), j.cnt);
    check("err", 32'(err), 32'(j.e));
    check("htrans_fin", 32'(bus.htrans), 0);
    check("busy_fin", 32'(busy), 0);
    check("busy_seen", 32'(bs), 32'(j.len != 0));
`ifdef AHB_COPY_CHECKSUM_EN
    check("checksum", checksum, sum);
`endif
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("htrans_after", 32'(bus.htrans), 0);
    check("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic        ds;
    //          src           dst          len wt er base cyc cnt e
    jobs[0] = '{32'h100,      32'h200,     4, 0, 0, 1, 17, 4, 1'b0};
    jobs[1] = '{32'h100,      32'h200,     4, 2, 0, 1, 33, 4, 1'b0};
    jobs[2] = '{32'h100,      32'h200,     0, 0, 0, 0,  1, 0, 1'b0};
    jobs[3] = '{32'h400,      32'h500,     3, 0, 2, 0,  9, 1, 1'b1};
    jobs[4] = '{32'h600,      32'h700,     1, 0, 0, 0,  5, 1, 1'b0};
    jobs[5] = '{32'hFFFFFFFC, 32'h300,     2, 0, 0, 0,  9, 2, 1'b0};
    jobs[6] = '{32'h803,      32'h902,     1, 0, 0, 0,  5, 1, 1'b0};
    jobs[7] = '{32'hA00,      32'hB00,     3, 1, 0, 0, 19, 3, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_htrans", 32'(bus.htrans), 0);
    check("rst_haddr", bus.haddr, 0);
    check("rst_hwrite", 32'(bus.hwrite), 0);
    check("rst_hwdata", bus.hwdata, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_count", 32'(count), 0);
`ifdef AHB_COPY_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    check("hsize", 32'(bus.hsize), 2);
    check("hburst", 32'(bus.hburst), 0);
    check("hprot", 32'(bus.hprot), 3);
    check("hmastlock", 32'(bus.hmastlock), 0);
    reset = 1'b0;

    for (int k = 0; k < 8; k++) run_job(jobs[k]);

    // Reset during WR_A of word 3; START while busy must be ignored
    waits      = 0;
    err_target = 0;
    for (int i = 0; i < 4; i++) begin
      a = 32'hC00 + 32'(4 * i);
      mem[a[11:2]] = $urandom;
      if (i < 2) exp_q.push_back('{32'hD00 + 32'(4 * i), mem[a[11:2]]});
    end
    @(negedge clk);
    start = 1'b1;
    src   = 32'hC00;
    dst   = 32'hD00;
    len   = 16'd4;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    len   = 16'd0;
    src   = 32'h0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_htrans", 32'(bus.htrans), 2);
    check("mid_hwrite", 32'(bus.hwrite), 1);
    check("mid_haddr", bus.haddr, 32'hD08);
    check("mid_count", 32'(count), 2);
    check("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("rr_htrans", 32'(bus.htrans), 0);
    check("rr_busy", 32'(busy), 0);
    check("rr_count", 32'(count), 0);
    check("rr_done", 32'(done), 0);
    check("rr_haddr", bus.haddr, 0);
    reset = 1'b0;
    ds = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || bus.htrans != 2'b00) ds = 1'b1;
    end
    check("rr_quiet", 32'(ds), 0);
    check("rr_sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
